// File: rtl/auth_resp_packetizer_pkg.sv
// Shared types and constants for the authentication response packetizer.
package auth_resp_packetizer_pkg;

  localparam int DEF_MSG_LEN    = 64;
  localparam int AUTH_HDR_BYTES = 4;

  typedef enum logic [1:0] {
    PKT_IDLE    = 2'd0,
    PKT_HDR     = 2'd1,
    PKT_PAYLOAD = 2'd2,
    PKT_ACK     = 2'd3
  } pkt_state_e;

  typedef struct packed {
    logic [7:0]  bm_request_type;
    logic [7:0]  b_request;
    logic [15:0] w_length;
  } auth_hdr_t;

  // Header wire order: type, request, length LSB, length MSB.
  function automatic logic [7:0] hdr_byte(input auth_hdr_t h, input logic [1:0] i);
    case (i)
      2'd0:    return h.bm_request_type;
      2'd1:    return h.b_request;
      2'd2:    return h.w_length[7:0];
      default: return h.w_length[15:8];
    endcase
  endfunction

endpackage

// File: rtl/auth_resp_packetizer_byte_mux_sel.sv
// Combinational byte picker: returns byte idx of a MSG_LEN-bit word, zero when out of range.
module byte_mux_sel #(
  parameter int MSG_LEN = 64,
  parameter int IDX_W   = $clog2(MSG_LEN/8) + 1
) (
  input  logic [MSG_LEN-1:0] msg,
  input  logic [IDX_W-1:0]   idx,
  output logic [7:0]         sel_byte
);

  localparam int MSG_BYTES = MSG_LEN / 8;

  logic [MSG_BYTES-1:0][7:0] bytes_w;
  logic [MSG_BYTES-1:0]      hit;

  assign bytes_w = msg;

  for (genvar i = 0; i < MSG_BYTES; i++) begin : g_hit
    assign hit[i] = (idx == IDX_W'(i));
  end

  // hit is one-hot (or empty), so an OR-reduction is a clean mux.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < MSG_BYTES; i++)
      sel_byte = sel_byte | ({8{hit[i]}} & bytes_w[i]);
  end

endmodule

// File: rtl/auth_resp_packetizer.sv
// Serializes one responder reply as a 4-byte header plus up to MSG_BYTES payload bytes
// on a valid/ready byte stream, then pulses Ack_out for one cycle.
module auth_resp_packetizer
  import auth_resp_packetizer_pkg::*;
#(
  parameter int MSG_LEN = DEF_MSG_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               resp_req_in,
  input  logic [7:0]         bmRequestType,
  input  logic [7:0]         bRequest,
  input  logic [15:0]        wLength,
  input  logic [MSG_LEN-1:0] auth_msg_in,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic               Ack_out,
  output logic               len_err
);

  localparam int MSG_BYTES = MSG_LEN / 8;
  localparam int CNT_W     = $clog2(MSG_BYTES) + 1;
  localparam logic [CNT_W-1:0] N_MAX    = CNT_W'(MSG_BYTES);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(AUTH_HDR_BYTES - 1);

  pkt_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, n_q, n_d;
  logic [CNT_W-1:0]   cnt_inc, cnt_inc2, pay_idx;
  logic               req_q, rise, hs, accept;
  auth_hdr_t          hdr_q;
  logic [MSG_LEN-1:0] msg_q;
  logic [7:0]         pay_byte, data_d;
  logic               valid_d, last_d, len_err_d;

  assign rise     = resp_req_in & ~req_q;
  assign hs       = tx_valid & tx_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_inc2 = cnt_q + CNT_W'(2);
  // Leaving HDR fetches payload byte 0; inside PAYLOAD we prefetch the following byte.
  assign pay_idx  = (state_q == PKT_PAYLOAD) ? cnt_inc : '0;

  byte_mux_sel #(.MSG_LEN(MSG_LEN), .IDX_W(CNT_W)) u_byte_mux_sel (
    .msg      (msg_q),
    .idx      (pay_idx),
    .sel_byte (pay_byte)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= PKT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    accept    = 1'b0;
    data_d    = tx_data;
    valid_d   = tx_valid;
    last_d    = tx_last;
    len_err_d = len_err;
    case (state_q)
      PKT_IDLE: begin
        if (rise) begin
          accept    = 1'b1;
          cnt_d     = '0;
          len_err_d = (wLength > 16'(MSG_BYTES));
          n_d       = (wLength > 16'(MSG_BYTES)) ? N_MAX : wLength[CNT_W-1:0];
          state_d   = PKT_HDR;
        end
      end
      PKT_HDR: begin
        if (!tx_valid) begin
          valid_d = 1'b1;
          data_d  = hdr_byte(hdr_q, cnt_q[1:0]);
          last_d  = (cnt_q == HDR_LAST) && (n_q == '0);
        end else if (hs) begin
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            if (n_q != '0) begin
              data_d  = pay_byte;
              last_d  = (n_q == CNT_W'(1));
              state_d = PKT_PAYLOAD;
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              data_d  = '0;
              state_d = PKT_ACK;
            end
          end else begin
            cnt_d  = cnt_inc;
            data_d = hdr_byte(hdr_q, cnt_inc[1:0]);
            last_d = (cnt_inc == HDR_LAST) && (n_q == '0);
          end
        end
      end
      PKT_PAYLOAD: begin
        if (hs) begin
          if (cnt_inc == n_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            state_d = PKT_ACK;
          end else begin
            cnt_d  = cnt_inc;
            data_d = pay_byte;
            last_d = (cnt_inc2 == n_q);
          end
        end
      end
      default: state_d = PKT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q    <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      hdr_q    <= '0;
      msg_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      Ack_out  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      req_q    <= resp_req_in;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      tx_data  <= data_d;
      tx_valid <= valid_d;
      tx_last  <= last_d;
      Ack_out  <= (state_d == PKT_ACK);
      len_err  <= len_err_d;
      if (accept) begin
        hdr_q <= {bmRequestType, bRequest, wLength};
        msg_q <= auth_msg_in;
      end
    end
  end

endmodule

// File: tb/tb_auth_resp_packetizer.sv
// Table-driven bench with an expected-byte scoreboard for auth_resp_packetizer.
module tb_auth_resp_packetizer;
  import auth_resp_packetizer_pkg::*;

  localparam int MSG_LEN   = 64;
  localparam int MSG_BYTES = MSG_LEN / 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               resp_req_in;
  logic [7:0]         bmRequestType, bRequest;
  logic [15:0]        wLength;
  logic [MSG_LEN-1:0] auth_msg_in;
  logic [7:0]         tx_data;
  logic               tx_valid, tx_last, tx_ready;
  logic               Ack_out, len_err;

  auth_resp_packetizer #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .resp_req_in(resp_req_in),
    .bmRequestType(bmRequestType), .bRequest(bRequest), .wLength(wLength),
    .auth_msg_in(auth_msg_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .Ack_out(Ack_out), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]         bmrt;
    logic [7:0]         breq;
    logic [15:0]        wlen;
    logic [MSG_LEN-1:0] msg;
    int                 mode;
    logic               exp_len_err;
    int                 exp_n;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   ack_cnt = 0, vcyc = 0, ready_mode = 0;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    logic [7:0] h[4];
    h[0] = v.bmrt; h[1] = v.breq; h[2] = v.wlen[7:0]; h[3] = v.wlen[15:8];
    for (int i = 0; i < 4 + v.exp_n; i++) begin
      exp_t e;
      e.d = (i < 4) ? h[i] : v.msg[8*(i-4) +: 8];
      e.l = (i == 3 + v.exp_n);
      q.push_back(e);
    end
  endtask

  task automatic wait_ack(input int a0);
    for (int c = 0; c < 300; c++) begin
      if (ack_cnt != a0) break;
      @(posedge clk); #1;
    end
    chk("ack_seen", ack_cnt, a0 + 1);
  endtask

  task automatic drive_req(input vec_t v);
    bmRequestType = v.bmrt;
    bRequest      = v.breq;
    wLength       = v.wlen;
    auth_msg_in   = v.msg;
    resp_req_in   = 1'b1;
  endtask

  task automatic scramble();
    bmRequestType = 8'($urandom);
    bRequest      = 8'($urandom);
    wLength       = 16'($urandom);
    auth_msg_in   = {$urandom, $urandom};
  endtask

  task automatic run_vec(input vec_t v);
    int a0;
    ready_mode = v.mode;
    push_exp(v);
    vcyc = 0;
    a0   = ack_cnt;
    drive_req(v);
    @(posedge clk); #1;
    chk("lat_k_valid", tx_valid, 0);
    resp_req_in = 1'b0;
    scramble();
    @(posedge clk); #1;
    chk("lat_k1_valid", tx_valid, 1);
    chk("lat_k1_data", tx_data, v.bmrt);
    wait_ack(a0);
    chk("len_err", len_err, v.exp_len_err);
    chk("queue_drained", q.size(), 0);
    if (v.mode == 0) chk("pkt_cycles", vcyc, 4 + v.exp_n);
  endtask

  // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
  initial begin
    int ph = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = (ready_mode == 0) ? 1'b1 : (ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, Ack timing.
  initial begin
    logic       stall_prev = 1'b0, exp_ack = 1'b0, ack_prev = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0; exp_ack = 1'b0; ack_prev = 1'b0;
      end else begin
        if (exp_ack) chk("ack_after_last", Ack_out, 1);
        exp_ack = 1'b0;
        if (ack_prev) chk("ack_one_cycle", Ack_out, 0);
        if (Ack_out) ack_cnt++;
        ack_prev = Ack_out;
        if (stall_prev) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, prev_d);
          chk("stall_last", tx_last, prev_l);
        end
        if (tx_valid) vcyc++;
        if (tx_valid && tx_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_byte actual=%0h required=none", tx_data);
          end else begin
            e = q.pop_front();
            chk("byte_data", tx_data, e.d);
            chk("byte_last", tx_last, e.l);
            if (e.l) exp_ack = 1'b1;
          end
        end
        stall_prev = tx_valid && !tx_ready;
        prev_d = tx_data;
        prev_l = tx_last;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   a0;
    bit   found;

    vecs[0] = '{8'hC1, 8'h19, 16'd4,  64'h8877665544332211, 0, 1'b0, 4};
    vecs[1] = '{8'hC1, 8'h19, 16'd0,  64'h8877665544332211, 0, 1'b0, 0};
    vecs[2] = '{8'hA1, 8'h02, 16'(MSG_BYTES + 10), 64'hF0E1D2C3B4A59687, 0, 1'b1, MSG_BYTES};
    vecs[3] = '{8'h41, 8'h05, 16'd2,  64'h0123456789ABCDEF, 0, 1'b0, 2};
    vecs[4] = '{8'hC1, 8'h19, 16'd4,  64'h8877665544332211, 1, 1'b0, 4};
    vecs[5] = '{8'h81, 8'h7E, 16'd8,  64'h5A5A3C3C0F0FFF00, 1, 1'b0, 8};

    reset = 1'b0; resp_req_in = 1'b0;
    bmRequestType = '0; bRequest = '0; wLength = '0; auth_msg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_ack", Ack_out, 0);
    chk("rst_len_err", len_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Request held high across Ack, plus an ignored edge mid-transfer.
    ready_mode = 0;
    v = vecs[3];
    push_exp(v);
    a0 = ack_cnt;
    drive_req(v);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    resp_req_in = 1'b0;
    @(posedge clk); #1;
    resp_req_in = 1'b1;
    wait_ack(a0);
    repeat (10) begin @(posedge clk); #1; end
    chk("hold_single_ack", ack_cnt, a0 + 1);
    chk("hold_no_extra", q.size(), 0);
    chk("hold_idle_valid", tx_valid, 0);
    resp_req_in = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // Reset while payload byte 2 is on the bus.
    ready_mode = 0;
    v = vecs[0];
    push_exp(v);
    drive_req(v);
    @(posedge clk); #1;
    resp_req_in = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == 8'h33) begin found = 1'b1; break; end
    end
    chk("rst_mid_reach", found, 1);
    reset = 1'b0;
    a0 = ack_cnt;
    @(posedge clk); #1;
    chk("rst_mid_valid", tx_valid, 0);
    chk("rst_mid_ack", Ack_out, 0);
    chk("rst_mid_state", dut.state_q, PKT_IDLE);
    q.delete();
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid_no_ack", ack_cnt, a0);
    chk("rst_mid_no_valid", tx_valid, 0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
